conv3x3_filter: RTL and testbench
=================================

# conv3x3_filter

Streaming 3×3 convolution stage directly downstream of the BRAM read module. It consumes the pixel stream (`pixel`/`pixel_valid`) and the 9-entry kernel register, and keeps two line buffers plus a 3×3 window. It emits valid-mode convolution results (26×26 per 28×28 image) through a small output FIFO with a ready/valid handshake. It asserts `interrupt` back to the reader to pause the pixel stream before the FIFO can overflow.

## Interface
- `PIXEL_SIZE`, 8, bits per pixel, unsigned.
- `KERNEL_SIZE`, 9, number of kernel coefficients.
- `KERNEL_WIDTH`, 12, coefficient width, signed two's complement integer.
- `IMAGE_WIDTH`, 28, pixels per row.
- `IMAGE_HEIGHT`, 28, rows per image.
- `ACC_WIDTH`, 25, signed result width; full precision, no truncation.
- `FIFO_DEPTH`, 8, output FIFO entries; power of two, minimum 8.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low.
- `pixel`  in  PIXEL_SIZE  pixel from the reader.
- `pixel_valid`  in  1  pixel is accepted on every cycle this is high.
- `kernel`  in  KERNEL_SIZE×KERNEL_WIDTH  packed kernel, index 0 = top-left, row-major; must be stable while streaming.
- `interrupt`  out  1  registered; high = reader must stop issuing pixels.
- `result`  out  ACC_WIDTH  FIFO head, signed.
- `result_valid`  out  1  FIFO not empty.
- `result_last`  out  1  head is the final result of an image.
- `result_ready`  in  1  consumer pops the head when `result_valid && result_ready`.
- `overflow`  out  1  sticky; set if a push hits a full FIFO.

## Operation
- Reset (`reset`=0 at a clock edge) clears `col`, `row`, window valid flags, pipeline valids, FIFO pointers/count, `interrupt`, and `overflow`. Outputs then read: `result_valid`=0, `result_last`=0, `interrupt`=0, `overflow`=0. Line-buffer/window contents need not be cleared.
- Every accepted pixel:
  - Shifts into the 3×3 window.
  - Is written to line buffer 0, while line buffer 0's old value at `col` moves to line buffer 1.
  - Advances `col`; at `IMAGE_WIDTH-1` wrap to 0 and advance `row`; at (`IMAGE_HEIGHT-1`, `IMAGE_WIDTH-1`) wrap both to 0 (next image).
- A window is complete when `row>=2 && col>=2` (pre-increment values). Only complete windows enter the MAC pipeline. Row/column gating makes stale line-buffer data across image boundaries harmless.
- The window's current pixel is the bottom-right element, multiplied by `kernel[8]`. The pixel from 2 rows and 2 columns earlier is multiplied by `kernel[0]`.
- Arithmetic:
  - Pixel zero-extended to signed PIXEL_SIZE+1 bits.
  - Product signed 21 bits.
  - Sum of 9 products signed ACC_WIDTH.
- `result_last` is tagged on the window at (`IMAGE_HEIGHT-1`, `IMAGE_WIDTH-1`).
- Occupancy = FIFO count + MAC pipeline valid bits. `interrupt` is registered as `occupancy >= FIFO_DEPTH-4`.
  - The 4-entry margin covers the pixel presented in the cycle `interrupt` rises, the reader's one-cycle state lag, and 2 in-flight products.
- Pixels arriving while `interrupt`=1 are still accepted, never dropped.
- Simultaneous push and pop on a full FIFO is legal and counts as no overflow. A push onto a full FIFO without a pop drops the value and sets `overflow`.

## Timing
- Pixel accepted at edge E0 → products registered at E1 → sum pushed into the FIFO at E2. `result_valid` is high in the cycle after E2 if the FIFO was empty.
- Steady-state throughput is 1 result/cycle.
- `interrupt` deasserts one edge after occupancy drops below the threshold.
- First result of an image comes from the (2·IMAGE_WIDTH+3)-th pixel, i.e. the 59th at the 28-pixel default.
- An image yields (IMAGE_WIDTH-2)·(IMAGE_HEIGHT-2) = 676 results.
- Reset mid-image: effective at that edge. The next accepted pixel is (0,0), and results not yet popped are discarded.

## Structure
- `conv_pkg`: `PIXEL_SIZE`, `KERNEL_SIZE`, `KERNEL_WIDTH`, `IMAGE_WIDTH`, `IMAGE_HEIGHT`, `ACC_WIDTH` constants, and a `result_t` struct {signed `data`, `last`}. The reader module imports the same constants.
- One sub-module: `sync_fifo` (parameterised width/depth, count output, full/empty, same clock and active-low synchronous reset). It stores `result_t`.
- Line buffers are inferred register arrays (IMAGE_WIDTH×PIXEL_SIZE each) inside `conv3x3_filter`.

## Test plan
- Identity kernel (`kernel[4]`=1, others 0), pixel(r,c)=(r·28+c) mod 256, `result_ready`=1 → 676 results equal to pixel(r+1,c+1) for r,c in 0..25; `result_last` on the 676th only; first `result_valid` 2 cycles after the 59th pixel edge.
- All kernel=1, all pixels=255 → every result 2295; `interrupt` never asserts.
- All kernel=12'hFFF (−1), all pixels=255 → every result −2295; sign-extended over 25 bits.
- `result_ready`=0 for 200 cycles during streaming, with a bench reader honouring `interrupt` with one-cycle lag → `interrupt` high once occupancy ≥4, `overflow` stays 0, ordered correct results after release.
- Two images back-to-back → second image's first result on its 59th pixel; 1352 results total; two `result_last` pulses.
- `reset` low for 1 cycle mid-image with FIFO non-empty → `result_valid`=0 next cycle; restreamed image produces the correct 676 results.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and the result record for the convolution datapath.
package conv_pkg;

  localparam int PIXEL_SIZE   = 8;
  localparam int KERNEL_SIZE  = 9;
  localparam int KERNEL_WIDTH = 12;
  localparam int IMAGE_WIDTH  = 28;
  localparam int IMAGE_HEIGHT = 28;
  localparam int ACC_WIDTH    = 25;

  // Zero-extended pixel times signed coefficient.
  localparam int PROD_WIDTH = PIXEL_SIZE + 1 + KERNEL_WIDTH;
  localparam int COL_WIDTH  = $clog2(IMAGE_WIDTH);
  localparam int ROW_WIDTH  = $clog2(IMAGE_HEIGHT);

  typedef struct packed {
    logic signed [ACC_WIDTH-1:0] data;
    logic                        last;
  } result_t;

  // Sign-extend one product to accumulator width.
  function automatic logic signed [ACC_WIDTH-1:0] sext_prod(
    input logic signed [PROD_WIDTH-1:0] p
  );
    return {{(ACC_WIDTH - PROD_WIDTH){p[PROD_WIDTH-1]}}, p};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a sticky overflow flag.
// A push onto a full FIFO succeeds only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointer, count and overflow bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the empty flag hides stale entries.
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/conv3x3_filter.sv
// Streaming valid-mode 3x3 convolution: two line buffers feed a 3x3 window,
// a registered multiply stage, then a combinational adder tree into a FIFO.
module conv3x3_filter
  import conv_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [PIXEL_SIZE-1:0]               pixel,
  input  logic                                pixel_valid,
  input  logic [KERNEL_SIZE*KERNEL_WIDTH-1:0] kernel,
  output logic                                interrupt,
  output logic signed [ACC_WIDTH-1:0]         result,
  output logic                                result_valid,
  output logic                                result_last,
  input  logic                                result_ready,
  output logic                                overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  logic [PIXEL_SIZE-1:0] line_buf0 [IMAGE_WIDTH];
  logic [PIXEL_SIZE-1:0] line_buf1 [IMAGE_WIDTH];
  logic [PIXEL_SIZE-1:0] win [3][3];

  logic [COL_WIDTH-1:0] col;
  logic [ROW_WIDTH-1:0] row;
  logic                 win_valid, win_last;
  logic                 prod_valid, prod_last;

  logic signed [PROD_WIDTH-1:0] pix_ext  [KERNEL_SIZE];
  logic signed [PROD_WIDTH-1:0] coef_ext [KERNEL_SIZE];
  logic signed [PROD_WIDTH-1:0] prod     [KERNEL_SIZE];
  logic signed [ACC_WIDTH-1:0]  acc;

  result_t          fifo_in, fifo_out;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic [OCC_W-1:0] occupancy;

  // Position tracking and pipeline valid/last tags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      win_last   <= 1'b0;
      prod_valid <= 1'b0;
      prod_last  <= 1'b0;
    end else begin
      win_valid  <= pixel_valid && (row >= ROW_WIDTH'(2)) && (col >= COL_WIDTH'(2));
      win_last   <= (row == ROW_WIDTH'(IMAGE_HEIGHT-1)) && (col == COL_WIDTH'(IMAGE_WIDTH-1));
      prod_valid <= win_valid;
      prod_last  <= win_last;
      if (pixel_valid) begin
        if (col == COL_WIDTH'(IMAGE_WIDTH-1)) begin
          col <= '0;
          row <= (row == ROW_WIDTH'(IMAGE_HEIGHT-1)) ? '0 : row + ROW_WIDTH'(1);
        end else begin
          col <= col + COL_WIDTH'(1);
        end
      end
    end
  end

  // Line buffers and window shift; the new column is {row-2, row-1, current}.
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2]      <= line_buf1[col];
      win[1][2]      <= line_buf0[col];
      win[2][2]      <= pixel;
      line_buf1[col] <= line_buf0[col];
      line_buf0[col] <= pixel;
    end
  end

  // Operand widening: pixel zero-extended, coefficient sign-extended.
  always_comb begin
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      pix_ext[i]  = PROD_WIDTH'($signed({1'b0, win[i/3][i%3]}));
      coef_ext[i] = PROD_WIDTH'($signed(kernel[i*KERNEL_WIDTH +: KERNEL_WIDTH]));
    end
  end

  // Registered products of the current window.
  always_ff @(posedge clk) begin
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      prod[i] <= pix_ext[i] * coef_ext[i];
    end
  end

  // Full-precision sum of the nine products.
  always_comb begin
    // NOTE: assigning a default first keeps this block free of inferred latches.
    acc = '0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      acc = acc + sext_prod(prod[i]);
    end
  end

  assign fifo_in = '{data: acc, last: prod_last};

  sync_fifo #(
    .WIDTH ($bits(result_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (prod_valid),
    .push_data (fifo_in),
    .pop       (result_ready),
    .pop_data  (fifo_out),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (overflow)
  );

  assign result       = fifo_out.data;
  assign result_valid = !fifo_empty;
  assign result_last  = fifo_out.last && !fifo_empty;

  assign occupancy = OCC_W'(fifo_count) + OCC_W'(win_valid) + OCC_W'(prod_valid);

  // Back-pressure request to the reader, leaving room for in-flight pixels.
  always_ff @(posedge clk) begin
    if (!reset) interrupt <= 1'b0;
    else        interrupt <= (occupancy >= OCC_W'(FIFO_DEPTH-4));
  end

endmodule

// File: tb/tb_conv3x3_filter.sv
// Self-checking bench: a direct 2-D convolution model produces the ordered
// list of expected results; a monitor compares every popped FIFO head.
module tb_conv3x3_filter;
  import conv_pkg::*;

  localparam int NRES = (IMAGE_WIDTH-2) * (IMAGE_HEIGHT-2);

  logic                                clk = 1'b0;
  logic                                reset;
  logic [PIXEL_SIZE-1:0]               pixel;
  logic                                pixel_valid;
  logic [KERNEL_SIZE*KERNEL_WIDTH-1:0] kernel;
  logic                                interrupt;
  logic signed [ACC_WIDTH-1:0]         result;
  logic                                result_valid;
  logic                                result_last;
  logic                                result_ready;
  logic                                overflow;

  conv3x3_filter dut (
    .clk          (clk),
    .reset        (reset),
    .pixel        (pixel),
    .pixel_valid  (pixel_valid),
    .kernel       (kernel),
    .interrupt    (interrupt),
    .result       (result),
    .result_valid (result_valid),
    .result_last  (result_last),
    .result_ready (result_ready),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int data; bit last; } exp_t;
  exp_t exp_q[$];

  int img [IMAGE_HEIGHT][IMAGE_WIDTH];
  int kv  [KERNEL_SIZE];

  int checks = 0;
  int errors = 0;
  int got_q[$];
  int pop_cyc[$];
  int p59_q[$];
  int last_cnt;
  int last_idx;
  bit saw_int;
  bit saw_ovf;
  bit int_prev;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i < 0 || i >= q.size()) return -999999;
    return q[i];
  endfunction

  // Direct definition of a valid-mode 3x3 convolution at top-left (r,c).
  function automatic int conv_at(input int r, input int c);
    int s = 0;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++)
        s += kv[kr*3 + kc] * img[r+kr][c+kc];
    return s;
  endfunction

  task automatic load_expect();
    exp_t e;
    for (int r = 0; r < IMAGE_HEIGHT-2; r++)
      for (int c = 0; c < IMAGE_WIDTH-2; c++) begin
        e.data = conv_at(r, c);
        e.last = (r == IMAGE_HEIGHT-3) && (c == IMAGE_WIDTH-3);
        exp_q.push_back(e);
      end
  endtask

  task automatic apply_kernel();
    for (int i = 0; i < KERNEL_SIZE; i++)
      kernel[i*KERNEL_WIDTH +: KERNEL_WIDTH] = KERNEL_WIDTH'(kv[i]);
  endtask

  task automatic clear_stats();
    got_q.delete();
    pop_cyc.delete();
    p59_q.delete();
    last_cnt = 0;
    last_idx = -1;
    saw_int  = 1'b0;
    saw_ovf  = 1'b0;
  endtask

  task automatic random_image();
    for (int r = 0; r < IMAGE_HEIGHT; r++)
      for (int c = 0; c < IMAGE_WIDTH; c++)
        img[r][c] = int'($urandom_range(0, 255));
  endtask

  task automatic random_kernel();
    for (int i = 0; i < KERNEL_SIZE; i++)
      kv[i] = int'($urandom_range(0, 4095)) - 2048;
  endtask

  // Feed pixels [first, first+n); with honor set the reader reacts to
  // interrupt one cycle late.
  task automatic stream_pixels(input int first, input int n, input bit honor);
    int idx   = first;
    int stall = 0;
    while (idx < first + n) begin
      pixel       = PIXEL_SIZE'(img[idx / IMAGE_WIDTH][idx % IMAGE_WIDTH]);
      pixel_valid = honor ? !int_prev : 1'b1;
      @(posedge clk);
      #1;
      if (pixel_valid) begin
        if (idx == 2*IMAGE_WIDTH + 2) p59_q.push_back(cyc);
        idx++;
        stall = 0;
      end else begin
        stall++;
        if (stall > 1000) begin
          check("stream_stall_timeout", stall, 0);
          break;
        end
      end
      int_prev = interrupt;
    end
    pixel_valid = 1'b0;
  endtask

  task automatic stream_image(input bit honor);
    load_expect();
    stream_pixels(0, IMAGE_WIDTH*IMAGE_HEIGHT, honor);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain_pending", exp_q.size(), 0);
    check("drain_fifo_empty", int'(result_valid), 0);
  endtask

  // Compare every popped head against the model, in order.
  always @(negedge clk) begin
    if (reset) begin
      if (interrupt) saw_int = 1'b1;
      if (overflow)  saw_ovf = 1'b1;
      if (result_valid && result_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result_data", int'(result), e.data);
          check("result_last", int'(result_last), int'(e.last));
        end
        if (result_last) begin
          last_cnt++;
          last_idx = got_q.size();
        end
        got_q.push_back(int'(result));
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    reset        = 1'b0;
    pixel        = '0;
    pixel_valid  = 1'b0;
    result_ready = 1'b1;
    kernel       = '0;
    int_prev     = 1'b0;
    clear_stats();
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("reset_result_valid", int'(result_valid), 0);
    check("reset_result_last",  int'(result_last),  0);
    check("reset_interrupt",    int'(interrupt),    0);
    check("reset_overflow",     int'(overflow),     0);

    // Identity kernel on a ramp image.
    for (int i = 0; i < KERNEL_SIZE; i++) kv[i] = 0;
    kv[4] = 1;
    for (int r = 0; r < IMAGE_HEIGHT; r++)
      for (int c = 0; c < IMAGE_WIDTH; c++)
        img[r][c] = (r*IMAGE_WIDTH + c) % 256;
    apply_kernel();
    clear_stats();
    stream_image(1'b0);
    drain();
    check("id_count",      got_q.size(), NRES);
    check("id_last_count", last_cnt, 1);
    check("id_last_index", last_idx, NRES-1);
    check("id_first",      q_at(got_q, 0), 29);
    check("id_final",      q_at(got_q, NRES-1), 242);
    check("id_latency",    q_at(pop_cyc, 0) - q_at(p59_q, 0), 2);

    // All-ones kernel, saturated pixels.
    for (int i = 0; i < KERNEL_SIZE; i++) kv[i] = 1;
    for (int r = 0; r < IMAGE_HEIGHT; r++)
      for (int c = 0; c < IMAGE_WIDTH; c++) img[r][c] = 255;
    apply_kernel();
    clear_stats();
    stream_image(1'b0);
    drain();
    check("ones_count", got_q.size(), NRES);
    check("ones_value", q_at(got_q, 100), 2295);
    check("ones_no_interrupt", int'(saw_int), 0);

    // All -1 kernel: negative results must be sign-extended.
    for (int i = 0; i < KERNEL_SIZE; i++) kv[i] = -1;
    apply_kernel();
    clear_stats();
    stream_image(1'b0);
    drain();
    check("neg_count", got_q.size(), NRES);
    check("neg_value", q_at(got_q, NRES-1), -2295);

    // Consumer stall with a reader that honours interrupt.
    random_image();
    random_kernel();
    apply_kernel();
    clear_stats();
    fork
      stream_image(1'b1);
      begin
        repeat (150) @(posedge clk);
        #1 result_ready = 1'b0;
        repeat (200) @(posedge clk);
        #1 result_ready = 1'b1;
      end
    join
    drain();
    check("stall_count",       got_q.size(), NRES);
    check("stall_interrupt",   int'(saw_int), 1);
    check("stall_no_overflow", int'(saw_ovf), 0);

    // Two different images back-to-back.
    random_kernel();
    apply_kernel();
    clear_stats();
    random_image();
    stream_image(1'b1);
    random_image();
    stream_image(1'b1);
    drain();
    check("b2b_count",      got_q.size(), 2*NRES);
    check("b2b_last_count", last_cnt, 2);
    check("b2b_latency1",   q_at(pop_cyc, 0) - q_at(p59_q, 0), 2);
    check("b2b_latency2",   q_at(pop_cyc, NRES) - q_at(p59_q, 1), 2);

    // Reset mid-image with results waiting in the FIFO.
    random_image();
    random_kernel();
    apply_kernel();
    clear_stats();
    load_expect();
    stream_pixels(0, 70, 1'b0);
    result_ready = 1'b0;
    stream_pixels(70, 4, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_valid", int'(result_valid), 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("mid_reset_valid",     int'(result_valid), 0);
    check("mid_reset_last",      int'(result_last),  0);
    check("mid_reset_interrupt", int'(interrupt),    0);
    exp_q.delete();
    int_prev     = 1'b0;
    result_ready = 1'b1;
    clear_stats();
    stream_image(1'b1);
    drain();
    check("restream_count",      got_q.size(), NRES);
    check("restream_last_count", last_cnt, 1);
    check("final_overflow",      int'(overflow), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
